// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard controller signal bundle
//
// Purpose: groups the pipeline-side status inputs and the hazard controls
// returned to the pipeline.
// Modports:
//   master - pipeline side: drives register/status fields, receives controls
//   slave  - hazard_ctrl side: reads register/status fields, drives controls
// Signals:
//   id_ex_mem_read, id_ex_reg_write, id_ex_rd   ID/EX load flag, write flag, dest
//   ex_mem_reg_write, ex_mem_rd                 EX/MEM write flag, dest
//   mem_wb_reg_write, mem_wb_rd                 MEM/WB write flag, dest
//   if_id_rs, if_id_rt                          IF/ID source registers
//   id_ex_rs, id_ex_rt                          ID/EX source registers
//   branch_taken                                taken branch/jump resolved in EX
//   stall, pc_write, if_id_write                bubble insert / update enables
//   if_id_flush, id_ex_flush                    squash pipeline registers
//   fwd_a, fwd_b                                EX operand select (00 RF, 10 EX/MEM, 01 MEM/WB)
interface hazard_ctrl_if #(
   parameter int REGADDR_WIDTH = 5
);
   logic                     id_ex_mem_read;
   logic                     id_ex_reg_write;
   logic [REGADDR_WIDTH-1:0] id_ex_rd;
   logic                     ex_mem_reg_write;
   logic [REGADDR_WIDTH-1:0] ex_mem_rd;
   logic                     mem_wb_reg_write;
   logic [REGADDR_WIDTH-1:0] mem_wb_rd;
   logic [REGADDR_WIDTH-1:0] if_id_rs;
   logic [REGADDR_WIDTH-1:0] if_id_rt;
   logic [REGADDR_WIDTH-1:0] id_ex_rs;
   logic [REGADDR_WIDTH-1:0] id_ex_rt;
   logic                     branch_taken;
   logic                     stall;
   logic                     pc_write;
   logic                     if_id_write;
   logic                     if_id_flush;
   logic                     id_ex_flush;
   logic [1:0]               fwd_a;
   logic [1:0]               fwd_b;

   modport master (
      output id_ex_mem_read, id_ex_reg_write, id_ex_rd,
             ex_mem_reg_write, ex_mem_rd, mem_wb_reg_write, mem_wb_rd,
             if_id_rs, if_id_rt, id_ex_rs, id_ex_rt, branch_taken,
      input  stall, pc_write, if_id_write, if_id_flush, id_ex_flush,
             fwd_a, fwd_b
   );

   modport slave (
      input  id_ex_mem_read, id_ex_reg_write, id_ex_rd,
             ex_mem_reg_write, ex_mem_rd, mem_wb_reg_write, mem_wb_rd,
             if_id_rs, if_id_rt, id_ex_rs, id_ex_rt, branch_taken,
      output stall, pc_write, if_id_write, if_id_flush, id_ex_flush,
             fwd_a, fwd_b
   );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, branch flush and forwarding control
//
// Purpose: detects load-use hazards and holds the front end for LOAD_STALL
// bubbles, squashes IF/ID and ID/EX on a taken branch, and selects EX operand
// forwarding sources.
// Configuration macro: HAZARD_CTRL_FWD_EN
//   defined   - fwd_a/fwd_b select EX/MEM (10) over MEM/WB (01) over RF (00)
//   undefined - no forwarding; RAW hazards on ID/EX or EX/MEM dests stall
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   hz  - hazard_ctrl_if.slave bundle (pipeline status in, controls out)
module hazard_ctrl #(
   parameter int REGADDR_WIDTH = 5,
   parameter int LOAD_STALL    = 1
) (
   input logic         clk,
   input logic         rst,
   hazard_ctrl_if.slave hz
);
   localparam logic [REGADDR_WIDTH-1:0] RZERO    = '0;
   localparam logic [3:0]               CNT_INIT = 4'(LOAD_STALL - 1);

   typedef enum logic {RUN, LSTALL} state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic       lu;
   logic       raw;
   logic [1:0] fwd_a_c, fwd_b_c;

   logic       stall_c, pc_write_c, if_id_write_c, flush_c;

   assign lu = hz.id_ex_mem_read && (hz.id_ex_rd != RZERO) &&
               ((hz.id_ex_rd == hz.if_id_rs) || (hz.id_ex_rd == hz.if_id_rt));

`ifdef HAZARD_CTRL_FWD_EN
   logic unused_rw;
   assign unused_rw = hz.id_ex_reg_write;
   assign raw       = 1'b0;

   always_comb begin
      fwd_a_c = 2'b00;
      fwd_b_c = 2'b00;
      if (hz.ex_mem_reg_write && (hz.ex_mem_rd != RZERO) && (hz.ex_mem_rd == hz.id_ex_rs))
         fwd_a_c = 2'b10;
      else if (hz.mem_wb_reg_write && (hz.mem_wb_rd != RZERO) && (hz.mem_wb_rd == hz.id_ex_rs))
         fwd_a_c = 2'b01;
      if (hz.ex_mem_reg_write && (hz.ex_mem_rd != RZERO) && (hz.ex_mem_rd == hz.id_ex_rt))
         fwd_b_c = 2'b10;
      else if (hz.mem_wb_reg_write && (hz.mem_wb_rd != RZERO) && (hz.mem_wb_rd == hz.id_ex_rt))
         fwd_b_c = 2'b01;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{hz.mem_wb_reg_write, hz.mem_wb_rd, hz.id_ex_rs, hz.id_ex_rt};

   // Without forwarding, any in-flight writer of an IF/ID source must drain first.
   assign raw = (hz.id_ex_reg_write && (hz.id_ex_rd != RZERO) &&
                 ((hz.id_ex_rd == hz.if_id_rs) || (hz.id_ex_rd == hz.if_id_rt))) ||
                (hz.ex_mem_reg_write && (hz.ex_mem_rd != RZERO) &&
                 ((hz.ex_mem_rd == hz.if_id_rs) || (hz.ex_mem_rd == hz.if_id_rt)));
   assign fwd_a_c = 2'b00;
   assign fwd_b_c = 2'b00;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The RUN cycle that detects the hazard is the first bubble, so LSTALL
   // only covers the remaining LOAD_STALL-1 bubbles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (lu && !hz.branch_taken && (LOAD_STALL > 1)) begin
               state_d = LSTALL;
               cnt_d   = CNT_INIT;
            end
         end
         LSTALL: begin
            if (hz.branch_taken) begin
               state_d = RUN;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1)
                  state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_comb begin
      stall_c       = 1'b0;
      pc_write_c    = 1'b1;
      if_id_write_c = 1'b1;
      flush_c       = 1'b0;
      if (rst) begin
         stall_c = 1'b0;
      end else if (hz.branch_taken) begin
         flush_c = 1'b1;
      end else if ((state_q == LSTALL) || lu || raw) begin
         stall_c       = 1'b1;
         pc_write_c    = 1'b0;
         if_id_write_c = 1'b0;
      end
   end

   assign hz.stall       = stall_c;
   assign hz.pc_write    = pc_write_c;
   assign hz.if_id_write = if_id_write_c;
   assign hz.if_id_flush = flush_c;
   assign hz.id_ex_flush = flush_c;
   assign hz.fwd_a       = rst ? 2'b00 : fwd_a_c;
   assign hz.fwd_b       = rst ? 2'b00 : fwd_b_c;
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REGADDR_WIDTH, default 5, SHALL set the register-address width of all rd/rs/rt ports.
REQ-002 Parameter LOAD_STALL, default 1, legal range 1..15, SHALL set the total bubble cycles per load-use hazard.
REQ-003 Ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- id_ex_mem_read  in  1  ID/EX instruction is a load.
- id_ex_reg_write  in  1  ID/EX instruction writes rd.
- id_ex_rd  in  REGADDR_WIDTH  ID/EX destination register.
- ex_mem_reg_write  in  1  EX/MEM instruction writes rd.
- ex_mem_rd  in  REGADDR_WIDTH  EX/MEM destination register.
- mem_wb_reg_write  in  1  MEM/WB instruction writes rd.
- mem_wb_rd  in  REGADDR_WIDTH  MEM/WB destination register.
- if_id_rs, if_id_rt  in  REGADDR_WIDTH each  IF/ID source registers.
- id_ex_rs, id_ex_rt  in  REGADDR_WIDTH each  ID/EX source registers (forwarding).
- branch_taken  in  1  taken branch/jump resolved in EX this cycle.
- stall  out  1  insert bubble (zeroed controls) into ID/EX.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID update enable.
- if_id_flush, id_ex_flush  out  1 each  squash that pipeline register.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.

Function
REQ-004 Register 0 SHALL never cause a hazard or forward; every rd comparison SHALL require rd != 0.
REQ-005 Load-use hazard (LU) SHALL be: id_ex_mem_read & id_ex_rd != 0 & (id_ex_rd == if_id_rs | id_ex_rd == if_id_rt).
REQ-006 FSM SHALL have two states: RUN and LSTALL; 4-bit counter cnt.
REQ-007 In RUN with LU: stall=1, pc_write=0, if_id_write=0 in the same cycle (combinational); if LOAD_STALL>1, next state LSTALL with cnt=LOAD_STALL-1; else remain RUN.
REQ-008 In LSTALL: stall=1, pc_write=0, if_id_write=0 regardless of inputs; cnt decrements each cycle; when cnt==1, next state RUN.
REQ-009 Total bubbles per LU SHALL equal exactly LOAD_STALL consecutive cycles; LU SHALL NOT be re-evaluated during LSTALL.
REQ-010 branch_taken=1 SHALL give if_id_flush=1, id_ex_flush=1, pc_write=1, stall=0, if_id_write=1, and SHALL override any stall in the same cycle.
REQ-011 branch_taken in LSTALL SHALL force next state RUN and cnt=0.
REQ-012 Otherwise: stall=0, pc_write=1, if_id_write=1, flushes=0.

Reset
REQ-013 rst=1 at a rising edge SHALL set state=RUN, cnt=0, aborting any stall in progress.
REQ-014 While rst=1, outputs SHALL be stall=0, pc_write=1, if_id_write=1, flushes=0, fwd_a=fwd_b=00.

Configuration
REQ-015 Macro HAZARD_CTRL_FWD_EN defined: fwd_a/fwd_b SHALL select 10 when ex_mem_reg_write & ex_mem_rd matches id_ex_rs/id_ex_rt, else 01 on a mem_wb_reg_write match, else 00; EX/MEM has priority.
REQ-016 Macro undefined: fwd_a=fwd_b=00 constantly; an additional RAW stall (stall=1, pc_write=0, if_id_write=0) SHALL be asserted combinationally while id_ex_reg_write or ex_mem_reg_write has nonzero rd matching if_id_rs/if_id_rt; no FSM state change; branch_taken still overrides.

Verification
REQ-017 LOAD_STALL=1, id_ex_mem_read=1, id_ex_rd=5, if_id_rs=5 -> stall=1, pc_write=0 for exactly 1 cycle; state stays RUN.
REQ-018 LOAD_STALL=3, same LU for one cycle then inputs cleared -> stall=1 for exactly 3 consecutive cycles, then 0.
REQ-019 id_ex_mem_read=1, id_ex_rd=0, if_id_rs=0 -> stall=0, pc_write=1.
REQ-020 LU and branch_taken=1 in the same cycle -> stall=0, both flushes=1, pc_write=1; rst=1 mid-LSTALL -> stall=0 the next cycle.
REQ-021 FWD_EN: ex_mem_rd=mem_wb_rd=7, both reg_write=1, id_ex_rs=7 -> fwd_a=10; without FWD_EN, id_ex_reg_write=1, id_ex_rd=3, if_id_rt=3 -> stall=1, fwd_b=00.
